// File: rtl/ir_key_dispatcher_if.sv
// Command handshake between the key dispatcher and the IR encoder.
// The dispatcher drives the command side; the encoder answers with enc_ready.
interface ir_key_dispatcher_if #(
    parameter int CMD_WIDTH = 32
);
    logic [CMD_WIDTH-1:0] cmd;
    logic                 cmd_valid;
    logic                 cmd_repeat;
    logic                 enc_ready;

    modport master (
        output cmd,
        output cmd_valid,
        output cmd_repeat,
        input  enc_ready
    );

    modport slave (
        input  cmd,
        input  cmd_valid,
        input  cmd_repeat,
        output enc_ready
    );
endinterface

// File: rtl/ir_key_dispatcher.sv
// Turns debounced key levels into IR command transfers: one first frame per press,
// then auto-repeat frames at a fixed cadence while the key stays held.
module ir_key_dispatcher #(
    parameter int                            NUM_KEYS      = 4,
    parameter int                            CMD_WIDTH     = 32,
    parameter logic [NUM_KEYS*CMD_WIDTH-1:0] CMD_TABLE     = '0,
    parameter bit                            REPEAT_EN     = 1'b1,
    parameter int                            REPEAT_DELAY  = 2700000,
    parameter int                            REPEAT_PERIOD = 2700000,
    localparam int KEY_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
    localparam int TIMER_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD,
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_KEYS-1:0]        key_state,
    ir_key_dispatcher_if.master        enc,
    output logic [KEY_W-1:0]           active_key,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        WAIT_RELEASE
    } state_t;

    localparam logic [TIMER_W-1:0] DELAY_LOAD  = TIMER_W'(REPEAT_DELAY);
    localparam logic [TIMER_W-1:0] PERIOD_LOAD = TIMER_W'(REPEAT_PERIOD);

    state_t               state;
    logic [TIMER_W-1:0]   timer;
    logic [CMD_WIDTH-1:0] cmd_q;
    logic                 valid_q;
    logic                 repeat_q;
    logic [KEY_W-1:0]     pick_idx;
    logic [CMD_WIDTH-1:0] pick_cmd;
    logic                 held;

    assign held          = key_state[active_key];
    assign enc.cmd       = cmd_q;
    assign enc.cmd_valid = valid_q;
    assign enc.cmd_repeat = repeat_q;
    assign busy          = (state != IDLE);

    // Scanning from the top down lets the lowest pressed index overwrite the rest.
    always_comb begin
        pick_idx = '0;
        pick_cmd = CMD_TABLE[CMD_WIDTH-1:0];
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_state[i]) begin
                pick_idx = KEY_W'(i);
                pick_cmd = CMD_TABLE[i*CMD_WIDTH +: CMD_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            cmd_q      <= '0;
            valid_q    <= 1'b0;
            repeat_q   <= 1'b0;
            active_key <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|key_state) begin
                        active_key <= pick_idx;
                        cmd_q      <= pick_cmd;
                        repeat_q   <= 1'b0;
                        valid_q    <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (valid_q && enc.enc_ready) begin
                        valid_q <= 1'b0;
                        if (REPEAT_EN) begin
                            timer <= repeat_q ? PERIOD_LOAD : DELAY_LOAD;
                            state <= WAIT;
                        end else begin
                            state <= WAIT_RELEASE;
                        end
                    end
                end
                // A release seen on the expiry cycle still wins: no repeat frame.
                WAIT: begin
                    if (!held) begin
                        state <= IDLE;
                    end else if (timer == TIMER_W'(1)) begin
                        valid_q  <= 1'b1;
                        repeat_q <= 1'b1;
                        state    <= SEND;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                WAIT_RELEASE: begin
                    if (!held) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_key_dispatcher.sv
// Bench for ir_key_dispatcher: a repeating and a non-repeating instance share stimulus
// and are both checked every cycle against a transfer-level reference model.
module tb_ir_key_dispatcher;

    localparam int          DELAY  = 8;
    localparam int          PERIOD = 4;
    localparam logic [31:0] W0 = 32'h10EF_00FF;
    localparam logic [31:0] W1 = 32'h20DF_01FE;
    localparam logic [31:0] W2 = 32'h30CF_02FD;
    localparam logic [31:0] W3 = 32'h40BF_03FC;
    localparam logic [127:0] TABLE = {W3, W2, W1, W0};

    logic [31:0] words [4] = '{W0, W1, W2, W3};

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_state;
    logic       ready;
    logic [1:0] key_r, key_n;
    logic       busy_r, busy_n;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;
    int     xfer_n_count = 0;

    ir_key_dispatcher_if #(.CMD_WIDTH(32)) enc_r ();
    ir_key_dispatcher_if #(.CMD_WIDTH(32)) enc_n ();

    assign enc_r.enc_ready = ready;
    assign enc_n.enc_ready = ready;

    ir_key_dispatcher #(
        .NUM_KEYS(4), .CMD_WIDTH(32), .CMD_TABLE(TABLE),
        .REPEAT_EN(1'b1), .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)
    ) dut_r (
        .clk(clk), .rst(rst), .key_state(key_state), .enc(enc_r.master),
        .active_key(key_r), .busy(busy_r)
    );

    ir_key_dispatcher #(
        .NUM_KEYS(4), .CMD_WIDTH(32), .CMD_TABLE(TABLE),
        .REPEAT_EN(1'b0), .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)
    ) dut_n (
        .clk(clk), .rst(rst), .key_state(key_state), .enc(enc_n.master),
        .active_key(key_n), .busy(busy_n)
    );

    always #5 clk = ~clk;

    // The model tracks a press as "being served" and schedules repeats by absolute cycle number.
    typedef struct {
        bit          fresh;
        bit          serving;
        bit          valid;
        bit          rep;
        int          key;
        logic [31:0] cmd;
        longint      due;
    } model_t;

    model_t m_r, m_n;

    typedef struct {
        logic [3:0] ks;
        bit         rdy;
        bit         v;
        bit         r;
        int         k;
        bit         b;
    } vec_t;

    vec_t tbl [33];

    function automatic model_t model_step(model_t m, bit r, logic [3:0] ks, bit rdy, bit ren, longint c);
        model_t n = m;
        if (r) begin
            n.fresh = 1; n.serving = 0; n.valid = 0; n.rep = 0;
            n.key = 0; n.cmd = '0; n.due = -1;
        end else if (!m.serving) begin
            if (ks != 4'b0) begin
                for (int i = 3; i >= 0; i--) if (ks[i]) n.key = i;
                n.cmd = words[n.key];
                n.serving = 1; n.valid = 1; n.rep = 0; n.fresh = 0;
            end
        end else if (m.valid) begin
            if (rdy) begin
                n.valid = 0;
                n.due   = ren ? c + (m.rep ? PERIOD : DELAY) : -1;
            end
        end else if (!ks[m.key]) begin
            n.serving = 0;
        end else if (m.due == c) begin
            n.valid = 1;
            n.rep   = 1;
        end
        return n;
    endfunction

    task automatic check_model(string name, model_t m, logic [31:0] c, logic v, logic rp,
                               logic [1:0] k, logic b);
        bit ok;
        ok = (v == m.valid) && (b == m.serving);
        if (m.fresh)   ok = ok && (c == 32'h0) && (rp == 1'b0) && (k == 2'd0);
        if (m.valid)   ok = ok && (c == m.cmd) && (rp == m.rep);
        if (m.serving) ok = ok && (k == 2'(m.key));
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL %s cyc=%0d got v=%b r=%b k=%0d b=%b cmd=%h, expected v=%b r=%b k=%0d b=%b cmd=%h",
                     name, cyc, v, rp, k, b, c, m.valid, m.rep, m.key, m.serving, m.cmd);
        end
    endtask

    task automatic check_output(string name, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s cyc=%0d got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic tick();
        if (enc_n.cmd_valid && ready) xfer_n_count++;
        @(posedge clk);
        cyc++;
        m_r = model_step(m_r, rst, key_state, ready, 1'b1, cyc);
        m_n = model_step(m_n, rst, key_state, ready, 1'b0, cyc);
        #1;
        check_model("model_rep",   m_r, enc_r.cmd, enc_r.cmd_valid, enc_r.cmd_repeat, key_r, busy_r);
        check_model("model_norep", m_n, enc_n.cmd, enc_n.cmd_valid, enc_n.cmd_repeat, key_n, busy_n);
    endtask

    task automatic apply_stimulus(logic [3:0] ks, bit rdy, bit r);
        key_state = ks;
        ready     = rdy;
        rst       = r;
        tick();
    endtask

    initial begin
        bit          ok;
        logic [31:0] held_cmd;
        logic [3:0]  rks;

        // Held key 1 with repeats due 8 edges after the first acceptance, then every 4.
        for (int i = 0; i < 30; i++) tbl[i] = '{ks: 4'b0010, rdy: 1'b1, v: 1'b0, r: 1'b0, k: 1, b: 1'b1};
        tbl[0].v = 1'b1;
        tbl[9].v = 1'b1;  tbl[9].r = 1'b1;
        tbl[14].v = 1'b1; tbl[14].r = 1'b1;
        tbl[19].v = 1'b1; tbl[19].r = 1'b1;
        tbl[24].v = 1'b1; tbl[24].r = 1'b1;
        tbl[29].v = 1'b1; tbl[29].r = 1'b1;
        tbl[30] = '{ks: 4'b0000, rdy: 1'b1, v: 1'b0, r: 1'b0, k: 1, b: 1'b1};
        tbl[31] = '{ks: 4'b0000, rdy: 1'b1, v: 1'b0, r: 1'b0, k: 1, b: 1'b0};
        tbl[32] = '{ks: 4'b0000, rdy: 1'b1, v: 1'b0, r: 1'b0, k: 1, b: 1'b0};

        m_r.due = -1;
        m_n.due = -1;
        key_state = 4'b0;
        ready     = 1'b1;
        rst       = 1'b1;

        apply_stimulus(4'b0000, 1'b1, 1'b1);
        apply_stimulus(4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) apply_stimulus(4'b0000, 1'b1, 1'b0);

        for (int i = 0; i < 33; i++) begin
            apply_stimulus(tbl[i].ks, tbl[i].rdy, 1'b0);
            ok = (enc_r.cmd_valid == tbl[i].v) && (busy_r == tbl[i].b);
            if (tbl[i].v) ok = ok && (enc_r.cmd_repeat == tbl[i].r) && (enc_r.cmd == words[tbl[i].k]);
            if (tbl[i].b) ok = ok && (key_r == 2'(tbl[i].k));
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("[TB] FAIL table_row%0d got v=%b r=%b k=%0d b=%b cmd=%h, expected v=%b r=%b k=%0d b=%b",
                         i, enc_r.cmd_valid, enc_r.cmd_repeat, key_r, busy_r, enc_r.cmd,
                         tbl[i].v, tbl[i].r, tbl[i].k, tbl[i].b);
            end
        end

        // Two keys at once: lowest index first, the other picked up after release.
        apply_stimulus(4'b1100, 1'b1, 1'b0);
        check_output("pair_first", {enc_r.cmd, 29'b0, enc_r.cmd_valid, key_r},
                     {W2, 29'b0, 1'b1, 2'd2});
        apply_stimulus(4'b1100, 1'b1, 1'b0);
        apply_stimulus(4'b1000, 1'b1, 1'b0);
        check_output("pair_idle", {63'b0, busy_r}, 64'd0);
        apply_stimulus(4'b1000, 1'b1, 1'b0);
        check_output("pair_second", {enc_r.cmd, 28'b0, enc_r.cmd_repeat, enc_r.cmd_valid, key_r},
                     {W3, 28'b0, 1'b0, 1'b1, 2'd3});
        for (int i = 0; i < 3; i++) apply_stimulus(4'b0000, 1'b1, 1'b0);

        // Encoder stalls while the key is released mid-stall.
        apply_stimulus(4'b0001, 1'b0, 1'b0);
        held_cmd = enc_r.cmd;
        check_output("stall_start", {32'b0, held_cmd}, {32'b0, W0});
        for (int i = 1; i < 10; i++) begin
            apply_stimulus((i >= 3) ? 4'b0000 : 4'b0001, 1'b0, 1'b0);
            check_output("stall_hold", {enc_r.cmd, 30'b0, enc_r.cmd_repeat, enc_r.cmd_valid},
                         {W0, 30'b0, 1'b0, 1'b1});
        end
        apply_stimulus(4'b0000, 1'b1, 1'b0);
        check_output("stall_accept", {62'b0, enc_r.cmd_valid, busy_r}, {62'b0, 1'b0, 1'b1});
        apply_stimulus(4'b0000, 1'b1, 1'b0);
        check_output("stall_idle", {62'b0, enc_r.cmd_valid, busy_r}, 64'd0);
        apply_stimulus(4'b0000, 1'b1, 1'b0);

        // Non-repeating instance: one transfer per press regardless of hold length.
        xfer_n_count = 0;
        for (int i = 0; i < 50; i++) apply_stimulus(4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus(4'b0000, 1'b1, 1'b0);
        check_output("norep_once", 64'(xfer_n_count), 64'd1);
        for (int i = 0; i < 10; i++) apply_stimulus(4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus(4'b0000, 1'b1, 1'b0);
        check_output("norep_twice", 64'(xfer_n_count), 64'd2);

        // Release on the very edge the repeat would have been requested.
        apply_stimulus(4'b0001, 1'b1, 1'b0);
        apply_stimulus(4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) apply_stimulus(4'b0001, 1'b1, 1'b0);
        check_output("expiry_before", {62'b0, enc_r.cmd_valid, busy_r}, {62'b0, 1'b0, 1'b1});
        apply_stimulus(4'b0000, 1'b1, 1'b0);
        check_output("expiry_release", {62'b0, enc_r.cmd_valid, busy_r}, 64'd0);
        apply_stimulus(4'b0000, 1'b1, 1'b0);
        check_output("expiry_after", {63'b0, enc_r.cmd_valid}, 64'd0);

        // Reset while a command is pending abandons it.
        apply_stimulus(4'b0100, 1'b0, 1'b0);
        check_output("pend_valid", {63'b0, enc_r.cmd_valid}, 64'd1);
        apply_stimulus(4'b0100, 1'b0, 1'b1);
        check_output("pend_reset", {enc_r.cmd, enc_n.cmd},
                     64'd0);
        check_output("pend_reset_flags",
                     {54'b0, enc_r.cmd_valid, enc_r.cmd_repeat, key_r, busy_r,
                      enc_n.cmd_valid, enc_n.cmd_repeat, key_n, busy_n}, 64'd0);
        apply_stimulus(4'b0000, 1'b1, 1'b0);

        rks = 4'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) rks = 4'($urandom_range(0, 15));
            apply_stimulus(rks, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
